// File: rtl/mdct_resonator_bank.sv
// Time-multiplexed bank of second-order resonators (y = x + coef*s1 - s2)
// sharing one multiplier; final s1 of each channel is streamed out per frame.
module mdct_resonator_bank #(
    parameter int DW   = 32,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int NCH  = 4,
    parameter int SAT  = 1,
    parameter int LW   = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_sys,
    input  logic              start,
    input  logic              abort,
    input  logic [LW-1:0]     frame_len,
    input  logic [NCH*CW-1:0] coef,
    input  logic [DW-1:0]     init_s1,
    input  logic [DW-1:0]     init_s2,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [CHW-1:0]    m_chan,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int PW = DW + CW;
    localparam int YW = DW + CW + 2;
    localparam logic signed [YW-1:0] YMAX = {{(YW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [YW-1:0] YMIN = {{(YW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CALC, S_DRAIN} state_t;

    state_t state, state_nx;

    logic signed [DW-1:0] s1 [NCH];
    logic signed [DW-1:0] s2 [NCH];
    logic signed [DW-1:0] x_reg;
    logic [LW-1:0]        cnt;
    logic [CHW-1:0]       ch;

    logic                 last_ch;
    logic signed [CW-1:0] c_sel;
    logic signed [DW-1:0] s1_sel;
    logic signed [DW-1:0] s2_sel;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] q;
    logic signed [YW-1:0] y_full;
    logic signed [DW-1:0] y_out;

    assign last_ch = (ch == CHW'(NCH - 1));

    always_comb begin
        c_sel  = coef[int'(ch)*CW +: CW];
        s1_sel = s1[ch];
        s2_sel = s2[ch];
        prod   = c_sel * s1_sel;
        q      = prod >>> FRAC;
        y_full = {{(YW-DW){x_reg[DW-1]}}, x_reg}
               + {{(YW-PW){q[PW-1]}}, q}
               - {{(YW-DW){s2_sel[DW-1]}}, s2_sel};
        y_out  = y_full[DW-1:0];
        if (SAT != 0) begin
            if (y_full > YMAX)
                y_out = YMAX[DW-1:0];
            else if (y_full < YMIN)
                y_out = YMIN[DW-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_sys) begin
        if (rst_sys)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // abort masks both handshakes so nothing is accepted in the flush cycle
    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        m_data   = '0;
        m_chan   = '0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = (frame_len != '0) ? S_WAIT : S_DRAIN;
            end
            S_WAIT: begin
                s_ready = !abort;
                if (s_valid)
                    state_nx = S_CALC;
            end
            S_CALC: begin
                if (last_ch)
                    state_nx = (cnt == LW'(1)) ? S_DRAIN : S_WAIT;
            end
            S_DRAIN: begin
                m_valid = !abort;
                m_data  = s1[ch];
                m_chan  = ch;
                m_last  = last_ch;
                if (m_ready && last_ch)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort)
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_sys) begin
        if (rst_sys) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                s1[i] <= '0;
                s2[i] <= '0;
            end
            x_reg <= '0;
            cnt   <= '0;
            ch    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            cnt <= frame_len;
                            ch  <= '0;
                            for (int unsigned i = 0; i < NCH; i++) begin
                                s1[i] <= init_s1;
                                s2[i] <= init_s2;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (s_valid) begin
                            x_reg <= s_data;
                            ch    <= '0;
                        end
                    end
                    S_CALC: begin
                        s1[ch] <= y_out;
                        s2[ch] <= s1_sel;
                        if (last_ch) begin
                            cnt <= cnt - LW'(1);
                            ch  <= '0;
                        end else begin
                            ch <= ch + CHW'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (m_ready) begin
                            if (last_ch) begin
                                done <= 1'b1;
                                ch   <= '0;
                            end else begin
                                ch <= ch + CHW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdct_resonator_bank.sv
// Directed bench: two NCH=2 banks (saturating and wrapping) share stimulus.
module tb_mdct_resonator_bank;
    logic        clk_in = 1'b0;
    logic        rst_sys;
    logic        start, abort, s_valid, m_ready;
    logic [15:0] frame_len;
    logic [31:0] coef;
    logic [31:0] init_s1, init_s2, s_data;

    logic        a_s_ready, a_m_valid, a_m_last, a_busy, a_done;
    logic [31:0] a_m_data;
    logic [0:0]  a_m_chan;
    logic        b_s_ready, b_m_valid, b_m_last, b_busy, b_done;
    logic [31:0] b_m_data;
    logic [0:0]  b_m_chan;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mdct_resonator_bank #(.DW(32), .CW(16), .FRAC(14), .NCH(2), .SAT(1), .LW(16)) dut_a (
        .clk_in(clk_in), .rst_sys(rst_sys), .start(start), .abort(abort),
        .frame_len(frame_len), .coef(coef), .init_s1(init_s1), .init_s2(init_s2),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_chan(a_m_chan),
        .m_last(a_m_last), .busy(a_busy), .done(a_done));

    mdct_resonator_bank #(.DW(32), .CW(16), .FRAC(14), .NCH(2), .SAT(0), .LW(16)) dut_b (
        .clk_in(clk_in), .rst_sys(rst_sys), .start(start), .abort(abort),
        .frame_len(frame_len), .coef(coef), .init_s1(init_s1), .init_s2(init_s2),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_chan(b_m_chan),
        .m_last(b_m_last), .busy(b_busy), .done(b_done));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_start(input logic [15:0] fl, input logic [31:0] c,
                            input logic [31:0] i1, input logic [31:0] i2);
        frame_len = fl; coef = c; init_s1 = i1; init_s2 = i2;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x);
        for (int i = 0; i < 20 && !a_s_ready; i++) tick();
        chk("s_ready_timeout", a_s_ready, 1);
        s_valid = 1'b1;
        s_data  = x;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain(input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] eb0, input logic [31:0] eb1, input int stall);
        m_ready = (stall == 0);
        for (int i = 0; i < 20 && !a_m_valid; i++) tick();
        chk("m_valid_timeout", a_m_valid, 1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_data", a_m_data, ea0);
            chk("stall_chan", a_m_chan, 0);
            tick();
        end
        m_ready = 1'b1;
        chk("r0_valid", a_m_valid, 1);
        chk("r0_chan", a_m_chan, 0);
        chk("r0_last", a_m_last, 0);
        chk("r0_data_sat", a_m_data, ea0);
        chk("r0_data_wrap", b_m_data, eb0);
        tick();
        chk("r1_valid", a_m_valid, 1);
        chk("r1_chan", a_m_chan, 1);
        chk("r1_last", a_m_last, 1);
        chk("r1_data_sat", a_m_data, ea1);
        chk("r1_data_wrap", b_m_data, eb1);
        tick();
        m_ready = 1'b0;
        chk("post_valid", a_m_valid, 0);
        chk("done_pulse_sat", a_done, 1);
        chk("done_pulse_wrap", b_done, 1);
        tick();
        chk("done_clear", a_done, 0);
        chk("idle_busy", a_busy, 0);
    endtask

    initial begin
        int acc [3];
        int n;
        rst_sys = 1'b1; start = 0; abort = 0; s_valid = 0; m_ready = 0;
        frame_len = '0; coef = '0; init_s1 = '0; init_s2 = '0; s_data = '0;
        #12;
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_m_data", a_m_data, 0);
        chk("rst_m_chan", a_m_chan, 0);
        rst_sys = 1'b0;
        tick();

        // basic frame: ch0 coef 1.0, ch1 coef 0, impulse input
        do_start(16'd4, {16'd0, 16'd16384}, 32'd0, 32'd0);
        chk("wait_busy", a_busy, 1);
        send(32'd1); send(32'd0); send(32'd0); send(32'd0);
        drain(32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, 0);

        // positive overflow
        do_start(16'd1, {16'd16384, 16'd16384}, 32'h7FFFFFFF, 32'd0);
        send(32'd1);
        drain(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 0);

        // negative overflow
        do_start(16'd1, {16'd16384, 16'd16384}, 32'h80000000, 32'h7FFFFFFF);
        send(32'd0);
        drain(32'h80000000, 32'h80000000, 32'h00000001, 32'h00000001, 0);

        // floor rounding of negative product: -3 >>> 14 = -1
        do_start(16'd1, {16'hFFFD, 16'hFFFD}, 32'd1, 32'd0);
        send(32'd0);
        drain(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

        // s_valid held high: acceptances every NCH+1 = 3 cycles
        do_start(16'd3, {16'd16384, 16'd16384}, 32'd0, 32'd0);
        s_valid = 1'b1; s_data = 32'd5; n = 0;
        for (int c = 0; c < 9; c++) begin
            if (a_s_ready && n < 3) begin
                acc[n] = c;
                n++;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("accept_count", n, 3);
        chk("accept_gap0", acc[1] - acc[0], 3);
        chk("accept_gap1", acc[2] - acc[1], 3);
        chk("drain_no_ready", a_s_ready, 0);
        drain(32'd10, 32'd10, 32'd10, 32'd10, 0);

        // downstream stall for 5 cycles
        do_start(16'd1, {16'd0, 16'd16384}, 32'd7, 32'd3);
        send(32'd2);
        drain(32'd6, 32'hFFFFFFFF, 32'd6, 32'hFFFFFFFF, 5);

        // frame_len = 0 goes straight to DRAIN; start while busy ignored
        do_start(16'd0, {16'd16384, 16'd16384}, 32'h1234, 32'd99);
        s_valid = 1'b1;
        chk("fl0_no_ready", a_s_ready, 0);
        chk("fl0_valid", a_m_valid, 1);
        frame_len = 16'd5; init_s1 = 32'h9999; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_data", a_m_data, 32'h1234);
        chk("busy_start_chan", a_m_chan, 0);
        s_valid = 1'b0;
        drain(32'h1234, 32'h1234, 32'h1234, 32'h1234, 0);

        // abort mid-CALC, then a clean frame
        do_start(16'd4, {16'd0, 16'd16384}, 32'd0, 32'd0);
        send(32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", a_busy, 0);
        chk("abort_m_valid", a_m_valid, 0);
        chk("abort_s_ready", a_s_ready, 0);
        chk("abort_done", a_done, 0);
        tick();
        chk("abort_done_late", a_done, 0);
        do_start(16'd4, {16'd0, 16'd16384}, 32'd0, 32'd0);
        send(32'd1); send(32'd0); send(32'd0); send(32'd0);
        drain(32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, 0);

        // async reset during DRAIN
        do_start(16'd0, {16'd0, 16'd0}, 32'h55, 32'h66);
        chk("pre_rst_valid", a_m_valid, 1);
        #2 rst_sys = 1'b1;
        #1;
        chk("rst_async_valid", a_m_valid, 0);
        chk("rst_async_busy", a_busy, 0);
        chk("rst_async_data", a_m_data, 0);
        chk("rst_s1_0", dut_a.s1[0], 0);
        chk("rst_s1_1", dut_a.s1[1], 0);
        chk("rst_s2_0", dut_a.s2[0], 0);
        chk("rst_s2_1", dut_a.s2[1], 0);
        tick();
        rst_sys = 1'b0;
        tick();
        chk("rst_idle_busy", a_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdct_resonator_bank.md
Name: mdct_resonator_bank

Overview:
- Time-multiplexed bank of NCH second-order recursive resonator cells for the MDCT/Goertzel path.
- Per-channel recurrence: y = x + ((coef*s1) >>> FRAC) - s2; then s2 <= s1, s1 <= y.
- One input sample is broadcast to all channels. A single shared multiplier updates one channel per cycle.
- After a programmable frame length, the final s1 of every channel is streamed out on a valid/ready port.

Parameters:
- DW, 32, data/state width (signed)
- CW, 16, coefficient width (signed, Q(CW-FRAC).FRAC)
- FRAC, 14, fractional bits of coef; product shifted right by FRAC
- NCH, 4, number of channels (>=1)
- SAT, 1, 1 = saturate y to DW, 0 = two's-complement wrap
- LW, 16, frame-length counter width

Ports:
- clk_in  in  1  clock
- rst_sys  in  1  asynchronous, active-high reset
- start  in  1  begin frame (honoured only in IDLE)
- abort  in  1  synchronous flush to IDLE
- frame_len  in  LW  samples per frame, latched at start
- coef  in  NCH*CW  per-channel coefficients, channel k at [k*CW +: CW], must be stable while busy
- init_s1  in  DW  preload for every s1 at start
- init_s2  in  DW  preload for every s2 at start
- s_valid  in  1  input sample valid
- s_ready  out  1  bank can accept a sample
- s_data  in  DW  signed input sample
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  DW  channel result (final s1)
- m_chan  out  clog2(NCH) (min 1)  channel index of m_data
- m_last  out  1  marks channel NCH-1 result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last result handshake

Behaviour:
- Reset (rst_sys=1, async): FSM=IDLE; all s1/s2 entries, counters and the sample register = 0. s_ready, m_valid, m_last, busy, done = 0. m_data = 0, m_chan = 0.
- States: IDLE, WAIT, CALC, DRAIN.
- IDLE:
  - On start=1: latch frame_len into cnt; load every s1 = init_s1 and every s2 = init_s2 in one cycle.
  - Next state is WAIT if frame_len != 0, otherwise DRAIN (outputs are init_s1).
- WAIT:
  - s_ready = 1.
  - On s_valid & s_ready: register s_data, set ch = 0, go to CALC.
- CALC:
  - s_ready = 0. One channel per cycle, ch = 0..NCH-1.
  - Each cycle: p = coef[ch]*s1[ch] (DW+CW bits); q = p >>> FRAC (arithmetic, floor); y = x + q - s2[ch], evaluated at DW+CW+2 bits.
  - SAT=1: clamp y to [-2^(DW-1), 2^(DW-1)-1]. SAT=0: keep the low DW bits.
  - Update s2[ch] <= s1[ch] and s1[ch] <= y.
  - After ch = NCH-1, decrement cnt. If cnt is now 0, go to DRAIN with ch = 0; otherwise go to WAIT.
- Latency and throughput:
  - Sample accepted at cycle T; channels are updated at T+1..T+NCH; s_ready returns high at T+NCH+1.
  - Maximum rate: one sample per NCH+1 cycles.
- DRAIN:
  - m_valid = 1, m_data = s1[ch], m_chan = ch, m_last = (ch == NCH-1).
  - Outputs are held stable while m_valid & !m_ready.
  - On handshake: ch++. After the handshake with m_last=1, m_valid drops, done pulses for one cycle, and the FSM goes to IDLE.
  - First m_valid is asserted the cycle after the final CALC cycle.
- start outside IDLE is ignored. s_valid outside WAIT is ignored and not buffered.
- abort (sync, highest priority after reset): in any state go to IDLE next cycle. m_valid, s_ready and busy drop; no done pulse; s1/s2 are not cleared. abort and start in the same IDLE cycle: abort wins.
- The state arrays hold their values in IDLE; a new start overwrites them.

Test Plan:
- NCH=2, FRAC=14, coef0=16384, coef1=0, init 0, frame_len=4, x = 1,0,0,0:
  - ch0 -> 1,1,0,-1 (result -1); ch1 -> 1,0,-1,0 (result 0).
  - m_chan 0 then 1, m_last on the second result, done one cycle after.
- Saturation, coef=16384, SAT=1:
  - init_s1=0x7FFFFFFF, init_s2=0, x=1, frame_len=1 -> result 0x7FFFFFFF.
  - init_s1=0x80000000, init_s2=0x7FFFFFFF, x=0 -> result 0x80000000.
  - Same two cases with SAT=0 -> 0x80000000 and 0x00000001 (wrap).
- Rounding: coef=-3, init_s1=1, init_s2=0, x=0, frame_len=1 -> q = -1, result 0xFFFFFFFF.
- Handshake:
  - s_valid held high continuously -> exactly one acceptance per NCH+1 cycles.
  - m_ready low for 5 cycles during DRAIN -> m_data/m_chan stable, no result lost or duplicated.
- frame_len=0 -> no s_ready; DRAIN outputs init_s1 for all channels. start while busy -> ignored.
- Reset/abort:
  - abort mid-CALC -> IDLE next cycle, no done; a following start reloads and the frame completes correctly.
  - rst_sys pulse mid-DRAIN -> m_valid 0 immediately, all state 0.
